// File: rtl/fir_pkg.sv
// Shared definitions for the moving-average FIR and its button helper.
//   clog2      : ceil(log2(value)) for sizing pointers, sums and counters
//   MODE_*     : encoding of the filter_mode output
//   sum_width  : width of a running sum that cannot overflow
package fir_pkg;

  localparam logic MODE_BYPASS = 1'b0;
  localparam logic MODE_AVG    = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Sum of 2**k samples of DATA_W bits needs k extra bits of headroom.
  function automatic int sum_width(input int data_w, input int taps);
    return data_w + clog2(taps);
  endfunction

endpackage

// File: rtl/btn_toggle.sv
// Pushbutton to single-cycle toggle pulse.
// Raw button -> 2-FF synchroniser -> (optional debounce) -> rising-edge detect.
// Build macro: MOVING_AVG_DEBOUNCE_EN adds a stability down-counter that
// requires DEBOUNCE_CYCLES consecutive equal samples before the debounced level
// follows the synchronised input (both press and release). Without the macro
// DEBOUNCE_CYCLES is unused and no counter exists.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw active-high button, asynchronous to clk
//   toggle_pulse out  one-cycle pulse per accepted press
module btn_toggle
  import fir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic toggle_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level;

`ifdef MOVING_AVG_DEBOUNCE_EN
  localparam int CNT_W = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // The counter reloads whenever the input agrees with the accepted level;
  // it only reaches zero after an unbroken run of disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = CNT_LOAD;
    if (sync2_q != stable_q) begin
      if (cnt_q == '0) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= CNT_LOAD;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign toggle_pulse = level & ~prev_q;

endmodule

// File: rtl/moving_avg_fir.sv
// N-tap moving-average FIR on a valid-qualified signed sample stream, with a
// pushbutton that toggles between averaging and bypass.
// Build macro: MOVING_AVG_DEBOUNCE_EN (passed through to btn_toggle).
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   toggle_btn  in   raw active-high pushbutton
//   in_valid    in   in_data valid this cycle
//   in_data     in   signed sample, DATA_W bits
//   out_valid   out  one-cycle strobe, out_data valid
//   out_data    out  signed average or bypassed sample, DATA_W bits
//   filter_mode out  1 = averaging, 0 = bypass
//   primed      out  TAPS samples seen since reset
module moving_avg_fir
  import fir_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int TAPS            = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     toggle_btn,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     filter_mode,
  output logic                     primed
);

  localparam int PTR_W = clog2(TAPS);
  localparam int SUM_W = sum_width(DATA_W, TAPS);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAPS - 1);

  logic signed [DATA_W-1:0] tap_q [TAPS];
  logic signed [DATA_W-1:0] tap_d [TAPS];
  logic signed [SUM_W-1:0]  sum_q, sum_d, sum_next;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     mode_q, mode_d;
  logic                     primed_q, primed_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     toggle_pulse;

  btn_toggle #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_toggle (
    .clk          (CLOCK_50),
    .rst_n        (rst_n),
    .btn_raw      (toggle_btn),
    .toggle_pulse (toggle_pulse)
  );

  always_comb begin
    tap_d       = tap_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    // A press takes effect next cycle; this cycle's sample still sees mode_q.
    mode_d      = mode_q ^ toggle_pulse;
    primed_d    = primed_q;

    // Oldest sample leaves the window as the new one enters.
    sum_next = sum_q + SUM_W'(in_data) - SUM_W'(tap_q[wr_ptr_q]);

    if (in_valid) begin
      tap_d[wr_ptr_q] = in_data;
      sum_d           = sum_next;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      count_d         = (count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_W'(1);
      primed_d        = primed_q | (count_d == CNT_FULL);
      if (mode_q == MODE_AVG) begin
        if (count_d == CNT_FULL) begin
          out_valid_d = 1'b1;
          // Arithmetic shift floors toward minus infinity; result fits DATA_W.
          out_data_d  = DATA_W'(sum_next >>> PTR_W);
        end
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      tap_q       <= '{default: '0};
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= MODE_AVG;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tap_q       <= tap_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign filter_mode = mode_q;
  assign primed      = primed_q;

endmodule
